// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-unit bus bundling memory, cpu handshake, branch flags and status.
interface inst_fetch_if #(parameter int ADDR_W = 8);
    logic              enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic [15:0]       d_inst;
    logic              run;
    logic              done;
    logic              flag_eq;
    logic              flag_gt;
    logic              flag_lt;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fault;
    logic [15:0]       retired;
    modport master (
        input  enable, mem_data, done, flag_eq, flag_gt, flag_lt,
        output mem_addr, d_inst, run, pc, busy, fault, retired
    );
    modport slave (
        output enable, mem_data, done, flag_eq, flag_gt, flag_lt,
        input  mem_addr, d_inst, run, pc, busy, fault, retired
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: PC-holding fetch stage; issues each instruction with a run pulse,
// waits for done, resolves format-10 branches and advances the PC.
module inst_fetch #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    inst_fetch_if.master  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT, NEXT, FAULT} state_t;
    localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int WW = $clog2(TIMEOUT);
    state_t            state_q;
    logic [LW-1:0]     lat_cnt_q;
    logic [WW-1:0]     wait_cnt_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       d_inst_q, retired_q;
    logic              run_q, fault_q, taken;
    always_comb begin
        taken = (d_inst_q[1:0] == 2'b10) &&
                (d_inst_q[3:2] == 2'b00 ? bus.flag_eq :
                 d_inst_q[3:2] == 2'b01 ? bus.flag_gt :
                 d_inst_q[3:2] == 2'b10 ? bus.flag_lt : 1'b1);
        pc_d  = taken ? d_inst_q[ADDR_W+3:4] : pc_q + ADDR_W'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            wait_cnt_q <= '0;
            pc_q       <= '0;
            d_inst_q   <= '0;
            retired_q  <= '0;
            run_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.enable) begin
                    state_q   <= FETCH;
                    lat_cnt_q <= '0;
                end
                FETCH: if (lat_cnt_q == LW'(MEM_LAT - 1)) state_q <= LOAD;
                       else lat_cnt_q <= lat_cnt_q + LW'(1);
                // run is raised here so it is high exactly during the ISSUE cycle
                LOAD: begin
                    d_inst_q <= bus.mem_data;
                    run_q    <= 1'b1;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: if (bus.done) state_q <= NEXT;
                      else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                          state_q <= FAULT;
                          fault_q <= 1'b1;
                      end else wait_cnt_q <= wait_cnt_q + WW'(1);
                NEXT: begin
                    retired_q <= retired_q + 16'd1;
                    pc_q      <= pc_d;
                    lat_cnt_q <= '0;
                    state_q   <= bus.enable ? FETCH : IDLE;
                end
                default: state_q <= FAULT;
            endcase
        end
    end
    assign bus.mem_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.d_inst   = d_inst_q;
    assign bus.run      = run_q;
    assign bus.fault    = fault_q;
    assign bus.retired  = retired_q;
    assign bus.busy     = (state_q != IDLE) && (state_q != FAULT);
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors for inst_fetch (MEM_LAT=1 main unit, MEM_LAT=3 latency unit).
module tb_inst_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    int   errs = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    inst_fetch_if #(.ADDR_W(8)) bus ();
    inst_fetch_if #(.ADDR_W(8)) bus2 ();
    inst_fetch #(.ADDR_W(8), .MEM_LAT(1), .TIMEOUT(64)) dut  (.clk(clk), .reset(reset),  .bus(bus));
    inst_fetch #(.ADDR_W(8), .MEM_LAT(3), .TIMEOUT(64)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));
    logic [15:0] mem [256];
    logic [15:0] p2 [3];
    always_ff @(posedge clk) begin
        bus.mem_data <= mem[bus.mem_addr];
        p2[0] <= mem[bus2.mem_addr];
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign bus2.mem_data = p2[2];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wait_run(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.run && n < 20);
        check({tag, "_run"}, 32'(bus.run), 1);
    endtask
    // Run one instruction: done two cycles after run, PC checked the cycle after NEXT.
    task automatic instr(input string tag, input logic [15:0] word, input logic [7:0] exp_pc,
                         input logic [15:0] exp_ret, input bit eq, input bit gt, input bit lt,
                         input bit drop, output int lat);
        bus.flag_eq = eq;
        bus.flag_gt = gt;
        bus.flag_lt = lt;
        wait_run(tag, lat);
        check({tag, "_dinst"}, 32'(bus.d_inst), 32'(word));
        @(negedge clk);
        check({tag, "_run1"}, 32'(bus.run), 0);
        if (drop) bus.enable = 1'b0;
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        @(negedge clk);
        check({tag, "_pc"}, 32'(bus.pc), 32'(exp_pc));
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_pc));
        check({tag, "_ret"}, 32'(bus.retired), 32'(exp_ret));
        check({tag, "_busy"}, 32'(bus.busy), drop ? 0 : 1);
    endtask
    initial begin
        int  lat;
        logic saw_run;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h2001;
        mem[8'h01] = 16'h005E;
        mem[8'h05] = 16'h0A2E;
        mem[8'hA2] = 16'h0302;
        mem[8'hA3] = 16'h0302;
        mem[8'h30] = 16'h0406;
        mem[8'h40] = 16'h0FFA;
        mem[8'hFF] = 16'h1234;
        bus.enable = 1'b1;
        bus.done = 1'b0;
        bus.flag_eq = 1'b0;
        bus.flag_gt = 1'b0;
        bus.flag_lt = 1'b0;
        bus2.enable = 1'b1;
        bus2.done = 1'b0;
        bus2.flag_eq = 1'b0;
        bus2.flag_gt = 1'b0;
        bus2.flag_lt = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pc", 32'(bus.pc), 0);
        check("rst_run", 32'(bus.run), 0);
        check("rst_dinst", 32'(bus.d_inst), 0);
        check("rst_fault", 32'(bus.fault), 0);
        check("rst_ret", 32'(bus.retired), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        // IDLE, then FETCH(c0) LOAD(c1) ISSUE(c2): run on the third negedge
        instr("t1", 16'h2001, 8'h01, 16'd1, 0, 0, 0, 0, lat);
        check("t1_lat", 32'(lat), 3);
        instr("br5",  16'h005E, 8'h05, 16'd2, 0, 0, 0, 0, lat);
        instr("t2",   16'h0A2E, 8'hA2, 16'd3, 0, 0, 0, 0, lat);
        instr("t3nt", 16'h0302, 8'hA3, 16'd4, 0, 1, 1, 0, lat);
        instr("t3tk", 16'h0302, 8'h30, 16'd5, 1, 0, 0, 0, lat);
        instr("gt",   16'h0406, 8'h40, 16'd6, 0, 1, 0, 0, lat);
        instr("lt",   16'h0FFA, 8'hFF, 16'd7, 0, 0, 1, 0, lat);
        instr("t4",   16'h1234, 8'h00, 16'd8, 0, 0, 0, 1, lat);
        saw_run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.done = (i == 2);
            @(negedge clk);
            saw_run |= bus.run;
        end
        bus.done = 1'b0;
        check("idle_run", 32'(saw_run), 0);
        check("idle_ret", 32'(bus.retired), 8);
        check("idle_busy", 32'(bus.busy), 0);
        bus.enable = 1'b1;
        wait_run("t5", lat);
        repeat (64) @(negedge clk);
        check("t5_nofault", 32'(bus.fault), 0);
        @(negedge clk);
        check("t5_fault", 32'(bus.fault), 1);
        check("t5_busy", 32'(bus.busy), 0);
        saw_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.done = i[0];
            @(negedge clk);
            saw_run |= bus.run;
        end
        bus.done = 1'b0;
        check("t5_run", 32'(saw_run), 0);
        check("t5_ret", 32'(bus.retired), 8);
        reset = 1'b1;
        @(negedge clk);
        check("t5_clr", 32'(bus.fault), 0);
        reset = 1'b0;
        instr("t6a", 16'h2001, 8'h01, 16'd1, 0, 0, 0, 0, lat);
        wait_run("t6b", lat);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_pc", 32'(bus.pc), 0);
        check("t6_run", 32'(bus.run), 0);
        check("t6_dinst", 32'(bus.d_inst), 0);
        check("t6_ret", 32'(bus.retired), 0);
        // MEM_LAT=3 adds two FETCH cycles before LOAD
        reset2 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus2.run && lat < 20);
        check("lat3_lat", 32'(lat), 5);
        check("lat3_dinst", 32'(bus2.d_inst), 32'h2001);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
